// File: rtl/mode_pkg.sv
// Shared types and default timing for the mode_clock link (generator and decoder).
// State encoding, mode codes and the nominal half-periods live here.
package mode_pkg;

    typedef enum logic [2:0] {
        ACQ0,
        ACQ1,
        CONF,
        LOCKED,
        STATIC
    } state_t;

    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    // Classifier result: MODE1..MODE3 for a matching interval, CLS_NONE otherwise.
    localparam logic [1:0] CLS_NONE = 2'd0;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MOD1_HALF   = 1000;
    localparam int DEF_MOD2_HALF   = 500;
    localparam int DEF_MOD3_HALF   = 200;
    localparam int DEF_TOL         = 20;
    localparam int DEF_TIMEOUT     = 4000;

    function automatic logic [3:0] mode_onehot(input logic [1:0] m);
        return 4'b0001 << m;
    endfunction

endpackage

// File: rtl/mode_clock_decoder_if.sv
// Link-side signals of the mode_clock decoder: the toggle input and the display outputs.
// master = generator/stimulus side, slave = decoder side.
interface mode_clock_decoder_if;

    logic        mode_clock;
    logic [15:0] LD;
    logic [1:0]  mode;
    logic        mode_valid;

    modport master (
        output mode_clock,
        input  LD,
        input  mode,
        input  mode_valid
    );

    modport slave (
        input  mode_clock,
        output LD,
        output mode,
        output mode_valid
    );

endinterface

// File: rtl/mode_clock_decoder_interval_meter.sv
// Synchronizer, toggle detector and saturating interval counter for mode_clock.
// edge_det pulses one cycle per toggle; meas is the running count, valid as the interval on edge_det.
module interval_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             edge_det,
    output logic [CNT_W-1:0] meas
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   last_p1;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            last_p1 <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
            last_p1 <= sync_p0[SYNC_STAGES-1];
            // Restart at 1 so toggles N cycles apart read back as exactly N.
            if (edge_det) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign edge_det = sync_p0[SYNC_STAGES-1] ^ last_p1;
    assign meas     = cnt;

endmodule

// File: rtl/mode_clock_decoder.sv
// Recovers the generator's switch mode from the mode_clock half-period and drives the LED running light.
// Optional macro LD_MODE_DISPLAY_EN: LD[15:12] shows the locked mode one-hot, light runs in LD[11:0].
module mode_clock_decoder
    import mode_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MOD1_HALF   = DEF_MOD1_HALF,
    parameter int MOD2_HALF   = DEF_MOD2_HALF,
    parameter int MOD3_HALF   = DEF_MOD3_HALF,
    parameter int TOL         = DEF_TOL,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic                 SCLK,
    input logic                 RST,
    mode_clock_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] M1_LO     = CNT_W'(MOD1_HALF - TOL);
    localparam logic [CNT_W-1:0] M1_HI     = CNT_W'(MOD1_HALF + TOL);
    localparam logic [CNT_W-1:0] M2_LO     = CNT_W'(MOD2_HALF - TOL);
    localparam logic [CNT_W-1:0] M2_HI     = CNT_W'(MOD2_HALF + TOL);
    localparam logic [CNT_W-1:0] M3_LO     = CNT_W'(MOD3_HALF - TOL);
    localparam logic [CNT_W-1:0] M3_HI     = CNT_W'(MOD3_HALF + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             edge_det;
    logic [CNT_W-1:0] meas;
    logic [1:0]       cls;

    state_t      state_q, state_d;
    logic [1:0]  cand_q, cand_d;
    logic [1:0]  mode_q, mode_d;
    logic        valid_q, valid_d;
    logic [15:0] ld_q, ld_d;
    logic [15:0] ld_lock, ld_rot, ld_static;

    function automatic logic [1:0] classify(input logic [CNT_W-1:0] m);
        if (m >= M1_LO && m <= M1_HI) return MODE1;
        if (m >= M2_LO && m <= M2_HI) return MODE2;
        if (m >= M3_LO && m <= M3_HI) return MODE3;
        return CLS_NONE;
    endfunction

    interval_meter #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) u_meter (
        .clk     (SCLK),
        .rst     (RST),
        .din     (bus.mode_clock),
        .edge_det(edge_det),
        .meas    (meas)
    );

    assign cls = classify(meas);

`ifdef LD_MODE_DISPLAY_EN
    assign ld_lock   = {mode_onehot(cand_q), 12'h001};
    assign ld_rot    = {mode_onehot(mode_q), ld_q[10:0], ld_q[11]};
    assign ld_static = {mode_onehot(MODE0), 12'h000};
`else
    assign ld_lock   = 16'h0001;
    assign ld_rot    = {ld_q[14:0], ld_q[15]};
    assign ld_static = 16'h0000;
`endif

    // ---- registered state and outputs ----
    always_ff @(posedge SCLK) begin
        if (RST) begin
            state_q <= ACQ0;
            cand_q  <= CLS_NONE;
            mode_q  <= MODE0;
            valid_q <= 1'b0;
            ld_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            ld_q    <= ld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        ld_d    = ld_q;
        if (edge_det) begin
            unique case (state_q)
                ACQ0: state_d = ACQ1;
                ACQ1: begin
                    if (cls != CLS_NONE) begin
                        cand_d  = cls;
                        state_d = CONF;
                    end
                end
                CONF: begin
                    if (cls == cand_q) begin
                        state_d = LOCKED;
                        mode_d  = cand_q;
                        valid_d = 1'b1;
                        ld_d    = ld_lock;
                    end else if (cls != CLS_NONE) begin
                        cand_d = cls;
                    end else begin
                        state_d = ACQ1;
                    end
                end
                LOCKED: begin
                    // A mismatching interval drops the lock but leaves mode and LD frozen.
                    if (cls == mode_q) begin
                        ld_d = ld_rot;
                    end else begin
                        state_d = ACQ1;
                        valid_d = 1'b0;
                    end
                end
                STATIC: begin
                    state_d = ACQ1;
                    valid_d = 1'b0;
                end
                default: state_d = ACQ0;
            endcase
        end else if (state_q != STATIC && meas == TIMEOUT_C) begin
            state_d = STATIC;
            mode_d  = MODE0;
            valid_d = 1'b1;
            ld_d    = ld_static;
        end
    end

    assign bus.LD         = ld_q;
    assign bus.mode       = mode_q;
    assign bus.mode_valid = valid_q;

endmodule

// File: tb/tb_mode_clock_decoder.sv
// Self-checking bench for mode_clock_decoder: toggle-interval scenarios plus randomized rates,
// checked against an event-level model of the decoding rules.
module tb_mode_clock_decoder;

    localparam int S       = 2;
    localparam int TOL     = 20;
    localparam int TIMEOUT = 4000;

    localparam int ST_ACQ0   = 0;
    localparam int ST_ACQ1   = 1;
    localparam int ST_CONF   = 2;
    localparam int ST_LOCKED = 3;
    localparam int ST_STATIC = 4;

    logic SCLK = 1'b0;
    logic RST  = 1'b1;
    int   cyc  = 0;
    int   last_tog = 0;
    int   total = 0;
    int   bad   = 0;

    int          m_st;
    int          m_cand;
    int          m_mode;
    logic        m_valid;
    logic [15:0] m_ld;

    mode_clock_decoder_if bus();

    mode_clock_decoder dut (
        .SCLK(SCLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 SCLK = ~SCLK;
    always @(posedge SCLK) cyc <= cyc + 1;

    function automatic int half_of(input int k);
        if (k == 1) return 1000;
        if (k == 2) return 500;
        return 200;
    endfunction

    function automatic int classify(input int m);
        int mm = (m > 65535) ? 65535 : m;
        for (int k = 1; k <= 3; k++) begin
            int d = mm - half_of(k);
            if (d < 0) d = -d;
            if (d <= TOL) return k;
        end
        return 0;
    endfunction

    function automatic logic [15:0] lock_pattern(input int k);
`ifdef LD_MODE_DISPLAY_EN
        return 16'((32'h1000 << k) | 32'h001);
`else
        return 16'h0001;
`endif
    endfunction

    function automatic logic [15:0] rotated(input logic [15:0] ld, input int k);
`ifdef LD_MODE_DISPLAY_EN
        int body = int'(ld) & 'hFFF;
        body = ((body << 1) | (body >> 11)) & 'hFFF;
        return 16'((32'h1000 << k) | body);
`else
        int v = int'(ld);
        return 16'(((v << 1) | (v >> 15)) & 'hFFFF);
`endif
    endfunction

    function automatic logic [15:0] static_pattern();
`ifdef LD_MODE_DISPLAY_EN
        return 16'h1000;
`else
        return 16'h0000;
`endif
    endfunction

    function void model_reset();
        m_st = ST_ACQ0; m_cand = 0; m_mode = 0; m_valid = 1'b0; m_ld = 16'h0000;
    endfunction

    function void model_timeout();
        m_st = ST_STATIC; m_mode = 0; m_valid = 1'b1; m_ld = static_pattern();
    endfunction

    // One detected toggle, m cycles after the previous one (or after reset release).
    function void model_edge(input int m);
        int k;
        if (m_st != ST_STATIC && m > TIMEOUT) model_timeout();
        k = classify(m);
        case (m_st)
            ST_ACQ0: m_st = ST_ACQ1;
            ST_ACQ1: if (k != 0) begin m_cand = k; m_st = ST_CONF; end
            ST_CONF: begin
                if (k == m_cand) begin
                    m_st = ST_LOCKED; m_mode = m_cand; m_valid = 1'b1; m_ld = lock_pattern(m_cand);
                end else if (k != 0) m_cand = k;
                else m_st = ST_ACQ1;
            end
            ST_LOCKED: begin
                if (k == m_mode) m_ld = rotated(m_ld, m_mode);
                else begin m_st = ST_ACQ1; m_valid = 1'b0; end
            end
            default: begin m_st = ST_ACQ1; m_valid = 1'b0; end
        endcase
    endfunction

    task automatic wait_cycles(input int k);
        repeat (k) begin
            @(posedge SCLK);
            @(negedge SCLK);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.mode_clock = 1'b0;
        wait_cycles(1);
        RST = 1'b0;
        model_reset();
        last_tog = cyc - S;
    endtask

    task automatic toggle();
        bus.mode_clock = ~bus.mode_clock;
        model_edge(cyc - last_tog);
        last_tog = cyc;
    endtask

    // Toggle n cycles after the previous toggle, then sit where the result is visible.
    task automatic gap(input int n);
        wait_cycles(n - (S + 1));
        toggle();
        wait_cycles(S + 1);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== 19'h0) begin
            bad++;
            $display("FAIL reset: got v=%0b m=%0d LD=%h, want all zero", bus.mode_valid, bus.mode, bus.LD);
        end
        wait_cycles(5);
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
            bad++;
            $display("FAIL reset_idle: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                     bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
        end
    endtask

    task automatic test_lock_mode1();
        do_reset();
        gap(60);
        gap(1000);
        wait_cycles(1000 - (S + 1));
        toggle();
        wait_cycles(S);
        total++;
        if (bus.mode_valid !== 1'b0) begin
            bad++;
            $display("FAIL lock1_early: got v=%0b, want v=0", bus.mode_valid);
        end
        wait_cycles(1);
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld} || bus.mode !== 2'd1) begin
            bad++;
            $display("FAIL lock1: got v=%0b m=%0d LD=%h, want v=%0b m=1 LD=%h",
                     bus.mode_valid, bus.mode, bus.LD, m_valid, m_ld);
        end
        for (int i = 1; i <= 17; i++) begin
            gap(1000);
            total++;
            if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
                bad++;
                $display("FAIL lock1_run[%0d]: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                         i, bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
            end
        end
    endtask

    task automatic test_modes_jitter();
        int hs[2] = '{200, 500};
        for (int r = 0; r < 2; r++) begin
            do_reset();
            gap(40);
            for (int i = 0; i < 5; i++) begin
                int j = int'($urandom_range(0, 2 * TOL)) - TOL;
                gap(hs[r] + j);
                total++;
                if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
                    bad++;
                    $display("FAIL modes_h%0d[%0d]: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                             hs[r], i, bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
                end
            end
            total++;
            if (bus.mode !== 2'(4 - 1 - r) || bus.mode_valid !== 1'b1) begin
                bad++;
                $display("FAIL modes_final_h%0d: got v=%0b m=%0d, want v=1 m=%0d",
                         hs[r], bus.mode_valid, bus.mode, 3 - r);
            end
        end
    endtask

    task automatic test_static();
        do_reset();
        wait_cycles(TIMEOUT);
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
            bad++;
            $display("FAIL static_before: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                     bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
        end
        wait_cycles(1);
        model_timeout();
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
            bad++;
            $display("FAIL static_enter: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                     bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
        end
        wait_cycles(300);
        toggle();
        wait_cycles(S);
        total++;
        if (bus.mode_valid !== 1'b1) begin
            bad++;
            $display("FAIL static_hold: got v=%0b, want v=1", bus.mode_valid);
        end
        wait_cycles(1);
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
            bad++;
            $display("FAIL static_exit: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                     bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
        end
    endtask

    task automatic test_tolerance();
        int seq[8] = '{1000, 1000, 980, 1020, 1021, 1000, 979, 1000};
        do_reset();
        gap(50);
        foreach (seq[i]) begin
            gap(seq[i]);
            total++;
            if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
                bad++;
                $display("FAIL tol[%0d]=%0d: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                         i, seq[i], bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
            end
        end
    endtask

    task automatic test_rate_switch();
        int seq[6] = '{500, 500, 500, 1000, 1000, 1000};
        do_reset();
        gap(30);
        foreach (seq[i]) begin
            gap(seq[i]);
            total++;
            if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
                bad++;
                $display("FAIL switch[%0d]: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                         i, bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
            end
        end
        total++;
        if (bus.mode !== 2'd1 || bus.mode_valid !== 1'b1) begin
            bad++;
            $display("FAIL switch_relock: got v=%0b m=%0d, want v=1 m=1", bus.mode_valid, bus.mode);
        end
    endtask

    task automatic test_reset_midlock();
        do_reset();
        gap(30);
        for (int i = 0; i < 4; i++) gap(200);
        wait_cycles(50);
        do_reset();
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== 19'h0) begin
            bad++;
            $display("FAIL midreset: got v=%0b m=%0d LD=%h, want all zero", bus.mode_valid, bus.mode, bus.LD);
        end
        gap(20);
        gap(200);
        total++;
        if (bus.mode_valid !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_2edges: got v=%0b, want v=0", bus.mode_valid);
        end
        gap(200);
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
            bad++;
            $display("FAIL midreset_relock: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                     bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
        end
    endtask

    task automatic test_edge_at_timeout();
        do_reset();
        wait_cycles(TIMEOUT - S);
        toggle();
        wait_cycles(S + 1);
        total++;
        if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld} || bus.mode_valid !== 1'b0) begin
            bad++;
            $display("FAIL edge_vs_timeout: got v=%0b m=%0d LD=%h, want v=0 m=%0d LD=%h",
                     bus.mode_valid, bus.mode, bus.LD, m_mode, m_ld);
        end
    endtask

    task automatic test_random();
        do_reset();
        gap(25);
        for (int run = 0; run < 7; run++) begin
            int k = int'($urandom_range(0, 3));
            int len = int'($urandom_range(2, 4));
            for (int i = 0; i < len; i++) begin
                int n;
                if (k == 0) n = int'($urandom_range(150, 1100));
                else n = half_of(k) + int'($urandom_range(0, 2 * TOL + 4)) - (TOL + 2);
                gap(n);
                total++;
                if ({bus.mode_valid, bus.mode, bus.LD} !== {m_valid, 2'(m_mode), m_ld}) begin
                    bad++;
                    $display("FAIL random[%0d.%0d] n=%0d: got v=%0b m=%0d LD=%h, want v=%0b m=%0d LD=%h",
                             run, i, n, bus.mode_valid, bus.mode, bus.LD, m_valid, m_mode, m_ld);
                end
            end
        end
    endtask

    initial begin
        bus.mode_clock = 1'b0;
        model_reset();
        wait_cycles(3);
        test_reset();
        test_lock_mode1();
        test_modes_jitter();
        test_static();
        test_tolerance();
        test_rate_switch();
        test_reset_midlock();
        test_edge_at_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
